// File: rtl/fir_channel_scheduler.sv
// Frames one sample per mic channel, issues the frame to a shared TDM FIR over AXI-stream
// in channel order, and demultiplexes the FIR output stream. Optional: STATUS_COUNTERS_EN.
module fir_channel_scheduler #(
  parameter int WIDTH          = 16,
  parameter int NUM_CH         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_CH-1:0]        mic_valid_in,
  input  logic [NUM_CH*WIDTH-1:0]  mic_data_in,
  output logic                     fir_s_tvalid_out,
  input  logic                     fir_s_tready_in,
  output logic [WIDTH-1:0]         fir_s_tdata_out,
  input  logic                     fir_m_tvalid_in,
  input  logic [WIDTH-1:0]         fir_m_tdata_in,
  output logic [NUM_CH*WIDTH-1:0]  filtered_out,
  output logic                     frame_valid_out,
  output logic [NUM_CH-1:0]        overrun_out,
  output logic                     timeout_out,
`ifdef STATUS_COUNTERS_EN
  output logic [7:0]               overrun_count_out,
  output logic [7:0]               timeout_count_out,
`endif
  input  logic                     clear_status_in
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0][WIDTH-1:0]   hold_q, hold_d;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [IDX_W-1:0]               issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]               out_idx_q, out_idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           tvalid_q, tvalid_d;
  logic [WIDTH-1:0]               tdata_q, tdata_d;
  logic [NUM_CH-1:0][WIDTH-1:0]   filt_q, filt_d;
  logic                           frame_valid_q, frame_valid_d;
  logic [NUM_CH-1:0]              overrun_q, overrun_d;
  logic                           timeout_q, timeout_d;

  logic                           hs_s;
  logic [IDX_W-1:0]               next_idx_s;
  logic [NUM_CH-1:0]              issued_s;
  logic [NUM_CH-1:0]              ovr_s;
  logic                           timeout_ev_s;

  // Capture, overrun detection and per-channel pending tracking
  always_comb begin
    hs_s       = tvalid_q & fir_s_tready_in;
    next_idx_s = issue_idx_q + IDX_W'(1);
    hold_d     = hold_q;
    pending_d  = pending_q;
    issued_s   = '0;
    ovr_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A channel already handed to the FIR (or handing over now) starts the next frame.
      issued_s[i] = (state_q == ISSUE) &&
                    ((IDX_W'(i) < issue_idx_q) || ((IDX_W'(i) == issue_idx_q) && hs_s));
      ovr_s[i]    = mic_valid_in[i] & pending_q[i] & ~issued_s[i];
      if (mic_valid_in[i]) begin
        hold_d[i]    = mic_data_in[i*WIDTH +: WIDTH];
        pending_d[i] = 1'b1;
      end else if (hs_s && (IDX_W'(i) == issue_idx_q)) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Frame sequencing: collect, time out, then drive the FIR slave stream
  always_comb begin
    state_d      = state_q;
    issue_idx_d  = issue_idx_q;
    cnt_d        = cnt_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    timeout_ev_s = 1'b0;
    case (state_q)
      COLLECT: begin
        if (&pending_q) begin
          state_d     = ISSUE;
          issue_idx_d = '0;
          tvalid_d    = 1'b1;
          tdata_d     = hold_d[0];
        end else if (|pending_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d      = ISSUE;
            issue_idx_d  = '0;
            tvalid_d     = 1'b1;
            tdata_d      = hold_d[0];
            timeout_ev_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ISSUE: begin
        if (hs_s) begin
          if (issue_idx_q == LAST_IDX) begin
            state_d     = COLLECT;
            issue_idx_d = '0;
            cnt_d       = '0;
            tvalid_d    = 1'b0;
          end else begin
            issue_idx_d = next_idx_s;
            tdata_d     = hold_d[next_idx_s];
          end
        end else begin
          tdata_d = tdata_q;
        end
      end
      default: begin
        state_d     = COLLECT;
        issue_idx_d = '0;
        cnt_d       = '0;
        tvalid_d    = 1'b0;
      end
    endcase
  end

  // Return-path demultiplex and sticky status flags
  always_comb begin
    filt_d        = filt_q;
    out_idx_d     = out_idx_q;
    frame_valid_d = 1'b0;
    if (fir_m_tvalid_in) begin
      filt_d[out_idx_q] = fir_m_tdata_in;
      if (out_idx_q == LAST_IDX) begin
        out_idx_d     = '0;
        frame_valid_d = 1'b1;
      end else begin
        out_idx_d = out_idx_q + IDX_W'(1);
      end
    end else begin
      out_idx_d = out_idx_q;
    end
    overrun_d = (overrun_q & {NUM_CH{~clear_status_in}}) | ovr_s;
    timeout_d = (timeout_q & ~clear_status_in) | timeout_ev_s;
  end

  // State registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= COLLECT;
      hold_q        <= '0;
      pending_q     <= '0;
      issue_idx_q   <= '0;
      out_idx_q     <= '0;
      cnt_q         <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      filt_q        <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      pending_q     <= pending_d;
      issue_idx_q   <= issue_idx_d;
      out_idx_q     <= out_idx_d;
      cnt_q         <= cnt_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      filt_q        <= filt_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign fir_s_tvalid_out = tvalid_q;
  assign fir_s_tdata_out  = tdata_q;
  assign filtered_out     = filt_q;
  assign frame_valid_out  = frame_valid_q;
  assign overrun_out      = overrun_q;
  assign timeout_out      = timeout_q;

`ifdef STATUS_COUNTERS_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [7:0] ovr_base_s, to_base_s;

  // Saturating event counters; an event in the clearing cycle still counts
  always_comb begin
    ovr_base_s = clear_status_in ? 8'd0 : ovr_cnt_q;
    to_base_s  = clear_status_in ? 8'd0 : to_cnt_q;
    if ((|ovr_s) && (ovr_base_s != 8'hFF)) begin
      ovr_cnt_d = ovr_base_s + 8'd1;
    end else begin
      ovr_cnt_d = ovr_base_s;
    end
    if (timeout_ev_s && (to_base_s != 8'hFF)) begin
      to_cnt_d = to_base_s + 8'd1;
    end else begin
      to_cnt_d = to_base_s;
    end
  end

  // Counter registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovr_cnt_q <= 8'd0;
      to_cnt_q  <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign overrun_count_out = ovr_cnt_q;
  assign timeout_count_out = to_cnt_q;
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: a vector table for the basic frame and return
// path, plus hand sequences for backpressure, reset, overrun and timeout.
module tb_fir_channel_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [2:0]  mic_valid_in;
  logic [47:0] mic_data_in;
  logic        fir_s_tvalid_out;
  logic        fir_s_tready_in;
  logic [15:0] fir_s_tdata_out;
  logic        fir_m_tvalid_in;
  logic [15:0] fir_m_tdata_in;
  logic [47:0] filtered_out;
  logic        frame_valid_out;
  logic [2:0]  overrun_out;
  logic        timeout_out;
  logic        clear_status_in;
`ifdef STATUS_COUNTERS_EN
  logic [7:0]  overrun_count_out;
  logic [7:0]  timeout_count_out;
`endif

  int checks = 0;
  int errors = 0;

  fir_channel_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .mic_valid_in     (mic_valid_in),
    .mic_data_in      (mic_data_in),
    .fir_s_tvalid_out (fir_s_tvalid_out),
    .fir_s_tready_in  (fir_s_tready_in),
    .fir_s_tdata_out  (fir_s_tdata_out),
    .fir_m_tvalid_in  (fir_m_tvalid_in),
    .fir_m_tdata_in   (fir_m_tdata_in),
    .filtered_out     (filtered_out),
    .frame_valid_out  (frame_valid_out),
    .overrun_out      (overrun_out),
    .timeout_out      (timeout_out),
`ifdef STATUS_COUNTERS_EN
    .overrun_count_out(overrun_count_out),
    .timeout_count_out(timeout_count_out),
`endif
    .clear_status_in  (clear_status_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  mv;
    logic [47:0] md;
    logic        rdy;
    logic        mtv;
    logic [15:0] mtd;
    logic        etv;
    logic [15:0] etd;
    logic [2:0]  eov;
    logic        efv;
    logic [47:0] efilt;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(input logic [2:0] mv, input logic [47:0] md);
    mic_valid_in = mv;
    mic_data_in  = md;
    tick();
    mic_valid_in = 3'b000;
  endtask

  // Expect an active tvalid with the given data at the current sample point, then advance.
  task automatic expect_issue(input string nm, input logic [15:0] d);
    chk({nm, "_tvalid"}, {63'd0, fir_s_tvalid_out}, 64'd1);
    chk({nm, "_tdata"}, {48'd0, fir_s_tdata_out}, {48'd0, d});
    tick();
  endtask

  initial begin
    int n;
    rst_in          = 1'b1;
    mic_valid_in    = 3'b000;
    mic_data_in     = 48'd0;
    fir_s_tready_in = 1'b1;
    fir_m_tvalid_in = 1'b0;
    fir_m_tdata_in  = 16'd0;
    clear_status_in = 1'b0;

    //           mv      md                                rdy   mtv   mtd       etv   etd       eov     efv   efilt
    vt[0]  = '{3'b001, {16'h0, 16'h0, 16'h1111},         1'b1, 1'b0, 16'h0,    1'b0, 16'h0,    3'b000, 1'b0, 48'h0};
    vt[1]  = '{3'b010, {16'h0, 16'h2222, 16'h0},         1'b1, 1'b0, 16'h0,    1'b0, 16'h0,    3'b000, 1'b0, 48'h0};
    vt[2]  = '{3'b100, {16'h3333, 16'h0, 16'h0},         1'b1, 1'b0, 16'h0,    1'b0, 16'h0,    3'b000, 1'b0, 48'h0};
    vt[3]  = '{3'b000, 48'h0,                            1'b1, 1'b0, 16'h0,    1'b1, 16'h1111, 3'b000, 1'b0, 48'h0};
    vt[4]  = '{3'b000, 48'h0,                            1'b1, 1'b0, 16'h0,    1'b1, 16'h2222, 3'b000, 1'b0, 48'h0};
    vt[5]  = '{3'b000, 48'h0,                            1'b1, 1'b0, 16'h0,    1'b1, 16'h3333, 3'b000, 1'b0, 48'h0};
    vt[6]  = '{3'b000, 48'h0,                            1'b1, 1'b0, 16'h0,    1'b0, 16'h0,    3'b000, 1'b0, 48'h0};
    vt[7]  = '{3'b000, 48'h0,                            1'b1, 1'b1, 16'h0A0A, 1'b0, 16'h0,    3'b000, 1'b0, 48'h0000_0000_0A0A};
    vt[8]  = '{3'b000, 48'h0,                            1'b1, 1'b1, 16'h0B0B, 1'b0, 16'h0,    3'b000, 1'b0, 48'h0000_0B0B_0A0A};
    vt[9]  = '{3'b000, 48'h0,                            1'b1, 1'b1, 16'h0C0C, 1'b0, 16'h0,    3'b000, 1'b1, 48'h0C0C_0B0B_0A0A};
    vt[10] = '{3'b000, 48'h0,                            1'b1, 1'b0, 16'h0,    1'b0, 16'h0,    3'b000, 1'b0, 48'h0C0C_0B0B_0A0A};

    tick();
    tick();
    chk("rst_tvalid", {63'd0, fir_s_tvalid_out}, 64'd0);
    chk("rst_filtered", {16'd0, filtered_out}, 64'd0);
    chk("rst_flags", {59'd0, frame_valid_out, overrun_out, timeout_out}, 64'd0);
    rst_in = 1'b0;
    tick();

    // Basic frame followed by a three-beat return.
    for (int r = 0; r < 11; r++) begin
      mic_valid_in    = vt[r].mv;
      mic_data_in     = vt[r].md;
      fir_s_tready_in = vt[r].rdy;
      fir_m_tvalid_in = vt[r].mtv;
      fir_m_tdata_in  = vt[r].mtd;
      tick();
      chk($sformatf("vec%0d_tvalid", r), {63'd0, fir_s_tvalid_out}, {63'd0, vt[r].etv});
      if (vt[r].etv) begin
        chk($sformatf("vec%0d_tdata", r), {48'd0, fir_s_tdata_out}, {48'd0, vt[r].etd});
      end
      chk($sformatf("vec%0d_overrun", r), {61'd0, overrun_out}, {61'd0, vt[r].eov});
      chk($sformatf("vec%0d_frame", r), {63'd0, frame_valid_out}, {63'd0, vt[r].efv});
      chk($sformatf("vec%0d_filtered", r), {16'd0, filtered_out}, {16'd0, vt[r].efilt});
    end
    mic_valid_in    = 3'b000;
    fir_m_tvalid_in = 1'b0;
    chk("basic_timeout", {63'd0, timeout_out}, 64'd0);

    // Backpressure on ch1; a ch1 capture coinciding with its handshake is not an overrun.
    strobe(3'b111, {16'h3333, 16'h2222, 16'h1111});
    tick();
    expect_issue("bp_ch0", 16'h1111);
    fir_s_tready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_tvalid", k), {63'd0, fir_s_tvalid_out}, 64'd1);
      chk($sformatf("bp_hold%0d_tdata", k), {48'd0, fir_s_tdata_out}, 64'h2222);
      tick();
    end
    fir_s_tready_in = 1'b1;
    strobe(3'b010, {16'h0, 16'h4444, 16'h0});
    chk("bp_ch2_tvalid", {63'd0, fir_s_tvalid_out}, 64'd1);
    chk("bp_ch2_tdata", {48'd0, fir_s_tdata_out}, 64'h3333);
    chk("bp_same_cycle_no_overrun", {61'd0, overrun_out}, 64'd0);
    tick();
    chk("bp_end_tvalid", {63'd0, fir_s_tvalid_out}, 64'd0);

    // ch1 stays pending with 0x4444; reset lands after the ch0 handshake of the next frame.
    strobe(3'b101, {16'h6666, 16'h0, 16'h5555});
    tick();
    chk("rs_ch0_tdata", {48'd0, fir_s_tdata_out}, 64'h5555);
    fir_m_tvalid_in = 1'b1;
    fir_m_tdata_in  = 16'hBEEF;
    tick();
    fir_m_tvalid_in = 1'b0;
    fir_s_tready_in = 1'b0;
    chk("rs_carry_ch1_tdata", {48'd0, fir_s_tdata_out}, 64'h4444);
    chk("rs_beat_filtered", {16'd0, filtered_out}, 64'h0C0C_0B0B_BEEF);
    #2 rst_in = 1'b1;
    #1;
    chk("rs_async_tvalid", {63'd0, fir_s_tvalid_out}, 64'd0);
    chk("rs_async_filtered", {16'd0, filtered_out}, 64'd0);
    tick();
    rst_in = 1'b0;
    fir_s_tready_in = 1'b1;
    strobe(3'b111, {16'h9999, 16'h8888, 16'h7777});
    chk("rs_pending_cleared", {61'd0, overrun_out}, 64'd0);
    tick();
    expect_issue("rs_f_ch0", 16'h7777);
    expect_issue("rs_f_ch1", 16'h8888);
    expect_issue("rs_f_ch2", 16'h9999);
    chk("rs_f_end", {63'd0, fir_s_tvalid_out}, 64'd0);
    fir_m_tvalid_in = 1'b1;
    fir_m_tdata_in  = 16'h1234;
    tick();
    fir_m_tvalid_in = 1'b0;
    chk("rs_out_idx0", {16'd0, filtered_out}, 64'h1234);
    chk("rs_out_frame", {63'd0, frame_valid_out}, 64'd0);

    // Two ch1 captures before issue: the newer sample is sent and ch1 overrun is flagged.
    strobe(3'b010, {16'h0, 16'h0001, 16'h0});
    chk("ov_first_no_flag", {61'd0, overrun_out}, 64'd0);
    strobe(3'b010, {16'h0, 16'h0002, 16'h0});
    chk("ov_flag", {61'd0, overrun_out}, 64'b010);
    strobe(3'b101, {16'h00C0, 16'h0, 16'h00A0});
    tick();
    expect_issue("ov_ch0", 16'h00A0);
    expect_issue("ov_ch1", 16'h0002);
    expect_issue("ov_ch2", 16'h00C0);
    chk("ov_sticky", {61'd0, overrun_out}, 64'b010);
    clear_status_in = 1'b1;
    tick();
    clear_status_in = 1'b0;
    chk("ov_cleared", {61'd0, overrun_out}, 64'd0);

    // Establish ch1 hold = 0x0BBB, then force-issue a frame missing ch1.
    strobe(3'b111, {16'h0CCC, 16'h0BBB, 16'h0AAA});
    tick();
    expect_issue("to_pre_ch0", 16'h0AAA);
    expect_issue("to_pre_ch1", 16'h0BBB);
    expect_issue("to_pre_ch2", 16'h0CCC);
    strobe(3'b101, {16'h00CC, 16'h0, 16'h00AA});
    chk("to_not_yet", {63'd0, timeout_out}, 64'd0);
    n = 0;
    while (fir_s_tvalid_out !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd1024);
    chk("to_flag", {63'd0, timeout_out}, 64'd1);
    expect_issue("to_ch0", 16'h00AA);
    expect_issue("to_ch1", 16'h0BBB);
    expect_issue("to_ch2", 16'h00CC);
    chk("to_end_tvalid", {63'd0, fir_s_tvalid_out}, 64'd0);
    chk("to_no_overrun", {61'd0, overrun_out}, 64'd0);
    clear_status_in = 1'b1;
    tick();
    clear_status_in = 1'b0;
    chk("to_cleared", {63'd0, timeout_out}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
